uart_pkt_gen: RTL and testbench



---
 rtl/uart_pkt_gen.sv | 155 +++++++++++++++
 tb/tb_uart_pkt_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_gen.sv
// Frame-synchronous telemetry packetiser: snapshots NUM_TGT boxes on vsync and streams
// header, box centres/edges, optional checksum (UART_PKT_CKSUM_EN) and CR LF to a byte UART.
module uart_pkt_gen #(
    parameter int         NUM_TGT  = 2,
    parameter logic [7:0] HDR_BYTE = 8'hFF,
    parameter int         HDR_LEN  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   uart_en,
    input  logic                   vsync_i,
    input  logic [3:0]             frame_div,
    input  logic [NUM_TGT*43-1:0]  tgt_bbox_i,
    input  logic                   tx_busy,
    output logic [7:0]             write_data,
    output logic                   write_en,
    output logic                   pkt_busy,
    output logic [7:0]             drop_cnt
);
    localparam int PAY_LEN = 12 * NUM_TGT;
`ifdef UART_PKT_CKSUM_EN
    localparam int CK_LEN = 1;
`else
    localparam int CK_LEN = 0;
`endif
    localparam int PKT_LEN = HDR_LEN + PAY_LEN + CK_LEN + 2;

    typedef enum logic [2:0] {IDLE, SNAP, CALC, SEND, WAIT} state_t;

    state_t                          state;
    logic                            vsync_d, tx_busy_d;
    logic [3:0]                      frame_cnt;
    logic [7:0]                      idx;
    logic [NUM_TGT-1:0][42:0]        snap;
    logic [NUM_TGT-1:0][10:0]        xc;
    logic [NUM_TGT-1:0][9:0]         yc;
    logic [NUM_TGT-1:0][5:0][10:0]   fld;
    logic [7:0]                      nxt_byte;
    logic                            is_pay, vs_rise, busy_fall, last, load;
    int                              sel;
`ifdef UART_PKT_CKSUM_EN
    logic [7:0]                      cksum;
`endif

    assign vs_rise   = vsync_i & ~vsync_d;
    assign busy_fall = tx_busy_d & ~tx_busy;
    assign last      = (int'(idx) == PKT_LEN - 1);
    assign load      = (state == CALC) || (state == WAIT && busy_fall && !last);

    // Payload fields in transmit order; an invalid target sends all zeros.
    always_comb begin
        fld = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (snap[k][42]) begin
                fld[k][0] = xc[k];
                fld[k][1] = {1'b0, yc[k]};
                fld[k][2] = snap[k][10:0];
                fld[k][3] = snap[k][31:21];
                fld[k][4] = {1'b0, snap[k][20:11]};
                fld[k][5] = {1'b0, snap[k][41:32]};
            end
        end
    end

    // Byte that the next load places on write_data.
    always_comb begin
        sel      = (state == CALC) ? 0 : int'(idx) + 1;
        is_pay   = (sel >= HDR_LEN) && (sel < HDR_LEN + PAY_LEN);
        nxt_byte = 8'h0A;
        if (sel < HDR_LEN) begin
            nxt_byte = HDR_BYTE;
        end else if (is_pay) begin
            for (int k = 0; k < NUM_TGT; k++) begin
                for (int f = 0; f < 6; f++) begin
                    if (sel == HDR_LEN + 12*k + 2*f)     nxt_byte = {5'b0, fld[k][f][10:8]};
                    if (sel == HDR_LEN + 12*k + 2*f + 1) nxt_byte = fld[k][f][7:0];
                end
            end
`ifdef UART_PKT_CKSUM_EN
        end else if (sel == HDR_LEN + PAY_LEN) begin
            nxt_byte = cksum;
`endif
        end else if (sel == PKT_LEN - 2) begin
            nxt_byte = 8'h0D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vsync_d    <= 1'b0;
            tx_busy_d  <= 1'b0;
            frame_cnt  <= '0;
            idx        <= '0;
            snap       <= '0;
            xc         <= '0;
            yc         <= '0;
            write_data <= '0;
            write_en   <= 1'b0;
            pkt_busy   <= 1'b0;
            drop_cnt   <= '0;
`ifdef UART_PKT_CKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            vsync_d   <= vsync_i;
            tx_busy_d <= tx_busy;
            write_en  <= 1'b0;
            if (vs_rise && uart_en && pkt_busy && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: if (vs_rise && uart_en) begin
                    frame_cnt <= (frame_cnt >= frame_div) ? 4'd0 : frame_cnt + 4'd1;
                    if (frame_cnt == 4'd0) begin
                        state    <= SNAP;
                        pkt_busy <= 1'b1;
                    end
                end
                SNAP: begin
                    snap  <= tgt_bbox_i;
`ifdef UART_PKT_CKSUM_EN
                    cksum <= '0;
`endif
                    state <= CALC;
                end
                CALC: begin
                    for (int k = 0; k < NUM_TGT; k++) begin
                        xc[k] <= 11'((12'(snap[k][10:0])  + 12'(snap[k][31:21])) >> 1);
                        yc[k] <= 10'((12'(snap[k][20:11]) + 12'(snap[k][41:32])) >> 1);
                    end
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: state <= WAIT;
                WAIT: if (busy_fall) begin
                    if (last) begin
                        state    <= IDLE;
                        pkt_busy <= 1'b0;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                write_en   <= 1'b1;
                write_data <= nxt_byte;
`ifdef UART_PKT_CKSUM_EN
                if (is_pay) cksum <= cksum + nxt_byte;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_pkt_gen.sv
// Bench for uart_pkt_gen: vector table, randomized packets against a byte-list model,
// drop/gating/reset/decimation sequences. Follows UART_PKT_CKSUM_EN like the design.
module tb_uart_pkt_gen;
    localparam int NT = 2;
    localparam int HL = 2;
`ifdef UART_PKT_CKSUM_EN
    localparam int CKL = 1;
`else
    localparam int CKL = 0;
`endif
    localparam int PLEN = HL + 12*NT + CKL + 2;

    logic              clk, reset, uart_en, vsync_i, tx_busy;
    logic [3:0]        frame_div;
    logic [NT*43-1:0]  tgt_bbox_i;
    logic [7:0]        write_data, drop_cnt;
    logic              write_en, pkt_busy;

    uart_pkt_gen #(.NUM_TGT(NT), .HDR_BYTE(8'hFF), .HDR_LEN(HL)) dut (
        .clk(clk), .reset(reset), .uart_en(uart_en), .vsync_i(vsync_i),
        .frame_div(frame_div), .tgt_bbox_i(tgt_bbox_i), .tx_busy(tx_busy),
        .write_data(write_data), .write_en(write_en), .pkt_busy(pkt_busy),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for 10 cycles per byte, or held busy on demand.
    int busy_cnt = 0;
    bit hold_busy = 0;
    assign tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (write_en) busy_cnt <= 10;
        else if (busy_cnt != 0 && !hold_busy) busy_cnt <= busy_cnt - 1;
    end

    logic [7:0] cap[$];
    always @(posedge clk) if (write_en) cap.push_back(write_data);

    int checks = 0, fails = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    function automatic logic [42:0] mk(input bit v, input int l, input int r, input int u, input int d);
        return {v, 10'(d), 11'(r), 10'(u), 11'(l)};
    endfunction

    function automatic logic [42:0] rnd_box();
        return mk(1'($urandom_range(0, 3) != 0), $urandom_range(0, 2047), $urandom_range(0, 2047),
                  $urandom_range(0, 1023), $urandom_range(0, 1023));
    endfunction

    // Reference packet: plain integer arithmetic over the box list.
    task automatic build_exp(input logic [NT*43-1:0] bb);
        int vals[6];
        int sum;
        logic [42:0] s;
        exp_q.delete();
        for (int h = 0; h < HL; h++) exp_q.push_back(8'hFF);
        sum = 0;
        for (int k = 0; k < NT; k++) begin
            s = bb[k*43 +: 43];
            if (s[42]) begin
                vals[2] = int'(s[10:0]);  vals[3] = int'(s[31:21]);
                vals[4] = int'(s[20:11]); vals[5] = int'(s[41:32]);
                vals[0] = (vals[2] + vals[3]) / 2;
                vals[1] = (vals[4] + vals[5]) / 2;
            end else begin
                for (int f = 0; f < 6; f++) vals[f] = 0;
            end
            for (int f = 0; f < 6; f++) begin
                exp_q.push_back(8'(vals[f] / 256));
                exp_q.push_back(8'(vals[f] % 256));
                sum += vals[f] / 256 + vals[f] % 256;
            end
        end
        if (CKL == 1) exp_q.push_back(8'(sum % 256));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse();
        @(negedge clk) vsync_i = 1'b1;
        @(negedge clk) vsync_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (pkt_busy && n < 5000) begin @(negedge clk); n++; end
        chk("pkt_done_timeout", int'(pkt_busy), 0);
    endtask

    task automatic check_pkt(input int base);
        int bad = 0;
        chk("pkt_len", cap.size() - base, PLEN);
        for (int i = 0; i < PLEN; i++)
            if (base + i >= cap.size() || cap[base+i] !== exp_q[i]) bad++;
        chk("pkt_bytes_mismatched", bad, 0);
    endtask

    task automatic run_pkt(input logic [NT*43-1:0] bb, input bit scramble, output int base);
        int lat = 0;
        base = cap.size();
        tgt_bbox_i = bb;
        build_exp(bb);
        @(negedge clk) vsync_i = 1'b1;
        do begin @(negedge clk); lat++; vsync_i = 1'b0; end while (!write_en && lat < 20);
        chk("first_we_latency", lat, 3);
        if (scramble) tgt_bbox_i = {rnd_box(), rnd_box()};
        wait_idle();
        check_pkt(base);
    endtask

    typedef struct {
        int l, r, u, d;
        bit v;
        int xc, yc, sum;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int base, n;
        tbl[0] = '{100, 300, 50, 150, 1'b1, 200, 100, 8'h85};
        tbl[1] = '{0, 0, 0, 0, 1'b1, 0, 0, 0};
        tbl[2] = '{2047, 2047, 1023, 1023, 1'b1, 2047, 1023, 8'h18};
        tbl[3] = '{1, 2, 3, 4, 1'b1, 1, 3, 8'h0E};
        tbl[4] = '{100, 300, 50, 150, 1'b0, 0, 0, 0};

        reset = 1'b1; uart_en = 1'b1; vsync_i = 1'b0; frame_div = 4'd0; tgt_bbox_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_write_en", int'(write_en), 0);
        chk("rst_pkt_busy", int'(pkt_busy), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_write_data", int'(write_data), 0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, target 1 always invalid
        for (int i = 0; i < 5; i++) begin
            run_pkt({mk(1'b0, 5, 6, 7, 8), mk(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d)}, 1'b0, base);
            chk("tbl_xc", int'({cap[base+2], cap[base+3]}), tbl[i].xc);
            chk("tbl_yc", int'({cap[base+4], cap[base+5]}), tbl[i].yc);
            if (CKL == 1) chk("tbl_cksum", int'(cap[base+HL+24]), tbl[i].sum);
        end

        // Gated edge: nothing sent, nothing counted
        uart_en = 1'b0;
        base = cap.size();
        pulse();
        repeat (30) @(negedge clk);
        chk("gated_bytes", cap.size() - base, 0);
        chk("gated_busy", int'(pkt_busy), 0);
        chk("gated_drop", int'(drop_cnt), 0);
        uart_en = 1'b1;

        // Random packets with inputs scrambled after the snapshot
        for (int i = 0; i < 6; i++) run_pkt({rnd_box(), rnd_box()}, 1'b1, base);

        // One dropped edge mid-packet
        base = cap.size();
        tgt_bbox_i = {rnd_box(), rnd_box()};
        build_exp(tgt_bbox_i);
        pulse();
        repeat (40) @(negedge clk);
        pulse();
        wait_idle();
        chk("drop_one", int'(drop_cnt), 1);
        check_pkt(base);

        // Saturation: stall the UART and hammer vsync
        hold_busy = 1;
        base = cap.size();
        tgt_bbox_i = {rnd_box(), rnd_box()};
        build_exp(tgt_bbox_i);
        pulse();
        repeat (20) @(negedge clk);
        repeat (300) pulse();
        chk("drop_sat", int'(drop_cnt), 255);
        chk("stalled_busy", int'(pkt_busy), 1);
        hold_busy = 0;
        wait_idle();
        check_pkt(base);

        // Reset after the fifth byte
        base = cap.size();
        tgt_bbox_i = {rnd_box(), rnd_box()};
        pulse();
        n = 0;
        while (cap.size() - base < 5 && n < 2000) begin @(negedge clk); n++; end
        chk("mid_bytes_before_reset", cap.size() - base, 5);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_write_en", int'(write_en), 0);
        chk("mid_rst_pkt_busy", int'(pkt_busy), 0);
        chk("mid_rst_drop", int'(drop_cnt), 0);
        reset = 1'b0;
        n = cap.size();
        repeat (200) @(negedge clk);
        chk("no_bytes_after_reset", cap.size() - n, 0);
        run_pkt({rnd_box(), rnd_box()}, 1'b0, base);
        chk("post_reset_first_byte", int'(cap[base]), 8'hFF);

        // Decimation: frame_div=2 sends on edges 1 and 4
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        frame_div = 4'd2;
        for (int e = 1; e <= 6; e++) begin
            base = cap.size();
            tgt_bbox_i = {rnd_box(), rnd_box()};
            build_exp(tgt_bbox_i);
            pulse();
            repeat (3) @(negedge clk);
            wait_idle();
            repeat (20) @(negedge clk);
            if (e == 1 || e == 4) check_pkt(base);
            else chk("decim_skipped_bytes", cap.size() - base, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
